// File: rtl/c1541_track_ctrl.sv
// Track buffer controller for a 1541 drive model: decodes the head stepper,
// waits for the head to settle, then writes back / reads whole GCR tracks over an SD request port.
module c1541_track_ctrl #(
  parameter logic [15:0] SETTLE = 16'd64000,
  parameter logic [6:0]  HT_MAX = 7'd83
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic [1:0] stp,
  input  logic       mtr,
  input  logic       mode,
  input  logic       wr_byte,
  input  logic       img_mounted,
  input  logic       sd_ack,
  input  logic       sd_done,
  output logic       sd_rd,
  output logic       sd_wr,
  output logic [5:0] sd_track,
  output logic [6:0] half_track,
  output logic       tr00_sense_n,
  output logic       ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_WB_REQ,
    S_WB_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_READY
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [6:0]  half_track_q, half_track_d;
  logic [1:0]  stp_prev_q;
  logic [1:0]  step_delta;
  logic [5:0]  loaded_track_q;
  logic        valid_q, dirty_q, img_pend_q;
  logic        sd_rd_q, sd_wr_q, ready_q;
  logic [5:0]  sd_track_q;
  logic [5:0]  cur_track_q, cur_track_d;
  logic        track_moved, need_load, img_now;

  // Head position after this cycle's stepper edge; all track decisions look at this value.
  always_comb begin
    half_track_d = half_track_q;
    step_delta   = stp - stp_prev_q;
    if (mtr && (stp != stp_prev_q)) begin
      if ((step_delta == 2'd1) && (half_track_q < HT_MAX)) begin
        half_track_d = half_track_q + 7'd1;
      end else if ((step_delta == 2'd3) && (half_track_q != 7'd0)) begin
        half_track_d = half_track_q - 7'd1;
      end
    end
  end

  assign cur_track_q = half_track_q[6:1];
  assign cur_track_d = half_track_d[6:1];
  assign track_moved = (cur_track_d != cur_track_q);
  assign need_load   = !valid_q || (cur_track_d != loaded_track_q) || img_mounted;
  assign img_now     = img_pend_q || img_mounted;

  // NOTE: all state below uses non-blocking assignments so every branch sees the
  // pre-edge values; a later assignment in the same cycle overrides an earlier one.
  always_ff @(posedge clk32) begin
    // NOTE: reset is synchronous, so the stepper phase is captured from the live input here.
    if (reset) begin
      state_q        <= S_SETTLE;
      cnt_q          <= SETTLE;
      half_track_q   <= 7'd34;
      stp_prev_q     <= stp;
      valid_q        <= 1'b0;
      dirty_q        <= 1'b0;
      loaded_track_q <= 6'd0;
      img_pend_q     <= 1'b0;
      sd_rd_q        <= 1'b0;
      sd_wr_q        <= 1'b0;
      sd_track_q     <= 6'd0;
      ready_q        <= 1'b0;
    end else begin
      half_track_q <= half_track_d;
      stp_prev_q   <= stp;

      // A new image invalidates the buffer; an in-flight transfer is remembered and finished first.
      if (img_mounted) begin
        valid_q <= 1'b0;
        dirty_q <= 1'b0;
        if (state_q inside {S_WB_REQ, S_WB_WAIT, S_RD_REQ, S_RD_WAIT}) begin
          img_pend_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (need_load) begin
            state_q <= S_SETTLE;
            cnt_q   <= SETTLE;
          end else if (mtr) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
          end
        end

        S_READY: begin
          if (need_load) begin
            state_q <= S_SETTLE;
            cnt_q   <= SETTLE;
            ready_q <= 1'b0;
          end else if (!mtr) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
          end else if (wr_byte && !mode) begin
            dirty_q <= 1'b1;
          end
        end

        S_SETTLE: begin
          if (track_moved || img_mounted) begin
            cnt_q <= SETTLE;
          end else if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (dirty_q && valid_q) begin
            state_q    <= S_WB_REQ;
            sd_wr_q    <= 1'b1;
            sd_track_q <= loaded_track_q;
          end else begin
            state_q    <= S_RD_REQ;
            sd_rd_q    <= 1'b1;
            sd_track_q <= cur_track_d;
          end
        end

        S_WB_REQ: begin
          if (sd_ack) begin
            state_q <= S_WB_WAIT;
            sd_wr_q <= 1'b0;
          end
        end

        S_WB_WAIT: begin
          if (sd_done) begin
            dirty_q <= 1'b0;
            if (img_now) begin
              state_q    <= S_SETTLE;
              cnt_q      <= SETTLE;
              img_pend_q <= 1'b0;
            end else begin
              state_q    <= S_RD_REQ;
              sd_rd_q    <= 1'b1;
              sd_track_q <= cur_track_d;
            end
          end
        end

        S_RD_REQ: begin
          if (sd_ack) begin
            state_q <= S_RD_WAIT;
            sd_rd_q <= 1'b0;
          end
        end

        S_RD_WAIT: begin
          if (sd_done) begin
            if (img_now) begin
              // Data came from the old image; leave the buffer invalid and start over.
              state_q    <= S_SETTLE;
              cnt_q      <= SETTLE;
              img_pend_q <= 1'b0;
            end else begin
              loaded_track_q <= sd_track_q;
              valid_q        <= 1'b1;
              if (cur_track_d == sd_track_q) begin
                state_q <= S_READY;
                ready_q <= 1'b1;
              end else begin
                state_q <= S_SETTLE;
                cnt_q   <= SETTLE;
              end
            end
          end
        end

        default: begin
          state_q <= S_SETTLE;
          cnt_q   <= SETTLE;
        end
      endcase
    end
  end

  assign sd_rd        = sd_rd_q;
  assign sd_wr        = sd_wr_q;
  assign sd_track     = sd_track_q;
  assign half_track   = half_track_q;
  assign tr00_sense_n = (half_track_q != 7'd0);
  assign ready        = ready_q;
  assign busy         = !((state_q == S_IDLE) || (state_q == S_READY));

endmodule

// File: tb/tb_c1541_track_ctrl.sv
// Self-checking bench for c1541_track_ctrl: a head-position model plus an SD host
// that acknowledges requests with random latency and checks their order and track.
module tb_c1541_track_ctrl;

  localparam logic [15:0] SETTLE_CYC = 16'd40;
  localparam int          HT_TOP     = 83;
  localparam int          BOUND      = 3 * SETTLE_CYC + 40;

  logic       clk32 = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] stp = 2'd0;
  logic       mtr = 1'b0, mode = 1'b1, wr_byte = 1'b0, img_mounted = 1'b0;
  logic       sd_ack = 1'b0, sd_done = 1'b0;
  logic       sd_rd, sd_wr, tr00_sense_n, ready, busy;
  logic [5:0] sd_track;
  logic [6:0] half_track;

  int         vectors = 0;
  int         miscompares = 0;
  int         model_ht = 34;
  logic [1:0] model_prev = 2'd0;

  always #5 clk32 = ~clk32;

  c1541_track_ctrl #(.SETTLE(SETTLE_CYC), .HT_MAX(7'(HT_TOP))) dut (
    .clk32(clk32), .reset(reset), .stp(stp), .mtr(mtr), .mode(mode),
    .wr_byte(wr_byte), .img_mounted(img_mounted), .sd_ack(sd_ack), .sd_done(sd_done),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_track(sd_track), .half_track(half_track),
    .tr00_sense_n(tr00_sense_n), .ready(ready), .busy(busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // One clock; outputs are sampled 1 time unit after the edge. Requests may never overlap.
  task automatic tick();
    @(posedge clk32);
    #1;
    vectors++;
    if (sd_rd && sd_wr) begin
      miscompares++;
      $display("FAIL req_overlap: got sd_rd=%0b sd_wr=%0b, want not both high", sd_rd, sd_wr);
    end
  endtask

  // Head model: a quarter-turn forward moves in one half-track, backward moves out, with clamps.
  function automatic int model_move(int ht, logic [1:0] prev, logic [1:0] nxt, logic motor);
    int quarter;
    quarter = (int'(nxt) - int'(prev) + 4) % 4;
    if (!motor) return ht;
    if (quarter == 1) return (ht < HT_TOP) ? ht + 1 : ht;
    if (quarter == 3) return (ht > 0) ? ht - 1 : ht;
    return ht;
  endfunction

  task automatic step_head(input int dir);
    logic [1:0] nxt;
    nxt = stp + 2'(dir);
    stp = nxt;
    tick();
    model_ht   = model_move(model_ht, model_prev, nxt, mtr);
    model_prev = nxt;
    vectors++;
    if (half_track !== 7'(model_ht) || tr00_sense_n !== (model_ht != 0)) begin
      miscompares++;
      $display("FAIL head_pos: got half_track=%0d tr00_n=%0b, want %0d tr00_n=%0b",
               half_track, tr00_sense_n, model_ht, model_ht != 0);
    end
  endtask

  task automatic wait_req(input string name, input bit want_rd, input int want_trk);
    int n;
    n = 0;
    while (!(sd_rd || sd_wr) && n < BOUND) begin
      tick();
      n++;
    end
    vectors++;
    if (sd_rd !== want_rd || sd_wr !== !want_rd || sd_track !== 6'(want_trk)) begin
      miscompares++;
      $display("FAIL %s: got rd=%0b wr=%0b track=%0d, want rd=%0b wr=%0b track=%0d",
               name, sd_rd, sd_wr, sd_track, want_rd, !want_rd, want_trk);
    end
  endtask

  task automatic ack_req(input string name);
    int hold;
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      tick();
      vectors++;
      if (!(sd_rd || sd_wr)) begin
        miscompares++;
        $display("FAIL %s_hold: got request low before ack, want held high", name);
      end
    end
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    vectors++;
    if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drop: got rd=%0b wr=%0b after ack, want both 0", name, sd_rd, sd_wr);
    end
  endtask

  task automatic done_xfer();
    repeat ($urandom_range(0, 4)) tick();
    sd_done = 1'b1;
    tick();
    sd_done = 1'b0;
  endtask

  task automatic serve(input string name, input bit want_rd, input int want_trk);
    wait_req(name, want_rd, want_trk);
    ack_req(name);
    done_xfer();
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got ready=%0b busy=%0b, want ready=1 busy=0", name, ready, busy);
    end
  endtask

  task automatic pulse_writes(input int count, input logic wmode);
    mode = wmode;
    for (int i = 0; i < count; i++) begin
      wr_byte = 1'b1;
      tick();
      wr_byte = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    mode = 1'b1;
  endtask

  // Step in one direction until the head sits on a different whole track.
  task automatic move_one_track(input int dir);
    int t0;
    t0 = model_ht / 2;
    while (model_ht / 2 == t0) step_head(dir);
  endtask

  task automatic test_reset();
    int n;
    mtr   = 1'b1;
    reset = 1'b1;
    stp   = ($urandom_range(0, 1) != 0) ? 2'd1 : 2'd3;
    repeat (3) tick();
    model_ht   = 34;
    model_prev = stp;
    vectors++;
    if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || sd_track !== 6'd0 || ready !== 1'b0 ||
        half_track !== 7'd34 || tr00_sense_n !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_vals: got rd=%0b wr=%0b trk=%0d rdy=%0b ht=%0d tr00_n=%0b, want 0 0 0 0 34 1",
               sd_rd, sd_wr, sd_track, ready, half_track, tr00_sense_n);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b1 || ready !== 1'b0 || half_track !== 7'd34) begin
      miscompares++;
      $display("FAIL reset_release: got busy=%0b ready=%0b ht=%0d, want 1 0 34", busy, ready, half_track);
    end
    n = 1;
    while (!sd_rd && n < BOUND) begin
      tick();
      n++;
    end
    vectors++;
    if (n < int'(SETTLE_CYC) || n > int'(SETTLE_CYC) + 2) begin
      miscompares++;
      $display("FAIL settle_time: got sd_rd after %0d cycles, want %0d..%0d",
               n, SETTLE_CYC, int'(SETTLE_CYC) + 2);
    end
    serve("first_read", 1'b1, 17);
    wait_ready("first_ready");
  endtask

  task automatic test_step();
    step_head(1);
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL step_same_track: got ready=%0b, want 1", ready);
    end
    step_head(1);
    vectors++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL step_new_track: got ready=%0b busy=%0b, want 0 1", ready, busy);
    end
    serve("step_read", 1'b1, model_ht / 2);
    wait_ready("step_ready");
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 40; i++) step_head(-1);
    vectors++;
    if (half_track !== 7'd0 || tr00_sense_n !== 1'b0) begin
      miscompares++;
      $display("FAIL track0: got ht=%0d tr00_n=%0b, want 0 0", half_track, tr00_sense_n);
    end
    for (int i = 0; i < 90; i++) step_head(1);
    vectors++;
    if (half_track !== 7'(HT_TOP)) begin
      miscompares++;
      $display("FAIL track_top: got ht=%0d, want %0d", half_track, HT_TOP);
    end
    for (int i = 0; i < 43; i++) step_head(-1);
    serve("boundary_read", 1'b1, model_ht / 2);
    wait_ready("boundary_ready");
  endtask

  // Head leaves the requested track in the same cycle the read completes.
  task automatic test_move_during_read();
    int c, r;
    c = model_ht / 2;
    do step_head(1); while ((model_ht % 2) != 0 || model_ht / 2 == c);
    r = model_ht / 2;
    wait_req("mdr_read", 1'b1, r);
    ack_req("mdr_read");
    step_head(1);
    sd_done = 1'b1;
    step_head(1);
    sd_done = 1'b0;
    vectors++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mdr_resettle: got ready=%0b busy=%0b, want 0 1", ready, busy);
    end
    serve("mdr_reread", 1'b1, r + 1);
    wait_ready("mdr_ready");
  endtask

  task automatic test_dirty_writeback();
    int t;
    t = model_ht / 2;
    pulse_writes(5, 1'b0);
    move_one_track(1);
    serve("wb_write", 1'b0, t);
    serve("wb_read", 1'b1, model_ht / 2);
    wait_ready("wb_ready");
  endtask

  task automatic test_read_mode_writes();
    pulse_writes(4, 1'b1);
    move_one_track(-1);
    serve("rmode_read", 1'b1, model_ht / 2);
    wait_ready("rmode_ready");
  endtask

  task automatic test_motor_off();
    int t;
    t = model_ht / 2;
    pulse_writes(2, 1'b0);
    mtr = 1'b0;
    tick();
    vectors++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL motor_off: got ready=%0b busy=%0b, want 0 0", ready, busy);
    end
    step_head(1);
    step_head(1);
    step_head(1);
    mtr = 1'b1;
    tick();
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0 || sd_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL motor_on: got ready=%0b busy=%0b rd=%0b, want 1 0 0", ready, busy, sd_rd);
    end
    move_one_track(1);
    serve("motor_wb", 1'b0, t);
    serve("motor_read", 1'b1, model_ht / 2);
    wait_ready("motor_ready");
  endtask

  task automatic test_img_mount();
    int r;
    pulse_writes(2, 1'b0);
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    vectors++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL img_settle: got ready=%0b busy=%0b, want 0 1", ready, busy);
    end
    serve("img_read", 1'b1, model_ht / 2);
    wait_ready("img_ready");
    move_one_track(1);
    r = model_ht / 2;
    wait_req("img_clean_read", 1'b1, r);
    ack_req("img_clean_read");
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    done_xfer();
    vectors++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL img_inflight: got ready=%0b busy=%0b, want 0 1", ready, busy);
    end
    serve("img_reread", 1'b1, r);
    wait_ready("img_reread_ready");
  endtask

  task automatic test_random_steps();
    int last, k, n;
    last = -1;
    for (int i = 0; i < 60; i++) begin
      mtr = ($urandom_range(0, 5) != 0);
      step_head(int'($urandom_range(0, 3)) - 1);
    end
    mtr = 1'b1;
    tick();
    k = 0;
    while (k < 4) begin
      n = 0;
      while (!(ready || sd_rd || sd_wr) && n < BOUND) begin
        tick();
        n++;
      end
      if (ready) break;
      vectors++;
      if (sd_rd !== 1'b1) begin
        miscompares++;
        $display("FAIL rand_req: got rd=%0b wr=%0b, want rd=1 wr=0", sd_rd, sd_wr);
      end
      last = int'(sd_track);
      ack_req("rand_req");
      done_xfer();
      k++;
    end
    vectors++;
    if (ready !== 1'b1 || last != model_ht / 2) begin
      miscompares++;
      $display("FAIL rand_final: got ready=%0b last_track=%0d, want 1 %0d", ready, last, model_ht / 2);
    end
  endtask

  task automatic test_reset_mid();
    move_one_track(1);
    wait_req("mid_read", 1'b1, model_ht / 2);
    reset = 1'b1;
    tick();
    model_ht   = 34;
    model_prev = stp;
    vectors++;
    if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || ready !== 1'b0 || half_track !== 7'd34) begin
      miscompares++;
      $display("FAIL reset_mid: got rd=%0b wr=%0b ready=%0b ht=%0d, want 0 0 0 34",
               sd_rd, sd_wr, ready, half_track);
    end
    reset = 1'b0;
    serve("post_reset_read", 1'b1, 17);
    wait_ready("post_reset_ready");
  endtask

  initial begin
    test_reset();
    test_step();
    test_boundary();
    test_move_during_read();
    test_dirty_writeback();
    test_read_mode_writes();
    test_motor_off();
    test_img_mount();
    test_random_steps();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/c1541_track_ctrl.md
C1541_TRACK_CTRL -- requirements
Module: c1541_track_ctrl

Interface
REQ-001 SETTLE, default 16'd64000, number of clk32 cycles the head track must stay stable before a load starts (2 ms at 32 MHz).
REQ-002 HT_MAX, default 7'd83, highest legal half-track index.
REQ-003 clk32  in  1  system clock; single clock domain.
REQ-004 reset  in  1  reset, synchronous and active-high.
REQ-005 stp  in  2  stepper phase from the drive logic.
REQ-006 mtr  in  1  spindle motor on.
REQ-007 mode  in  1  head mode; 0 = write, 1 = read.
REQ-008 wr_byte  in  1  one-cycle strobe; one GCR byte was written into the track buffer.
REQ-009 img_mounted  in  1  one-cycle strobe; a new disk image was inserted.
REQ-010 sd_ack  in  1  SD side accepted the pending request.
REQ-011 sd_done  in  1  one-cycle strobe; the accepted transfer has completed.
REQ-012 sd_rd  out  1  request to read track sd_track into the buffer.
REQ-013 sd_wr  out  1  request to write the buffer back to track sd_track.
REQ-014 sd_track  out  6  zero-based track number of the current request.
REQ-015 half_track  out  7  current head half-track position, 0..HT_MAX.
REQ-016 tr00_sense_n  out  1  low when half_track == 0.
REQ-017 ready  out  1  buffer holds the track under the head and may be streamed.
REQ-018 busy  out  1  high in any state other than IDLE and READY.

Function
REQ-019 Stepper decode: when mtr=1 and stp changes, compute d = (stp_new - stp_prev) mod 4.
- d=1: increment half_track, saturating at HT_MAX.
- d=3: decrement half_track, saturating at 0.
- d=2: no move.
- stp_prev updates on every change.
REQ-020 When mtr=0, stp changes update stp_prev but do not move the head.
REQ-021 cur_track = half_track[6:1]. The block keeps internal loaded_track (6 bits), valid (1 bit) and dirty (1 bit).
REQ-022 FSM states: IDLE, SETTLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, READY.
REQ-023 IDLE/READY -> SETTLE when any of these holds:
- valid=0
- cur_track != loaded_track
- img_mounted pulse
Entering SETTLE loads the settle counter with SETTLE and deasserts ready in the same cycle.
REQ-024 SETTLE decrements once per cycle; any cur_track change reloads the counter.
REQ-025 SETTLE at count 0 -> WB_REQ if dirty=1 and valid=1, else -> RD_REQ.
REQ-026 WB_REQ: sd_wr=1 and sd_track=loaded_track, held until sd_ack=1; then -> WB_WAIT with sd_wr=0.
REQ-027 WB_WAIT: on sd_done, clear dirty, then -> RD_REQ.
REQ-028 RD_REQ: sd_rd=1 and sd_track=cur_track (sampled on entry and held), held until sd_ack=1; then -> RD_WAIT with sd_rd=0.
REQ-029 RD_WAIT: on sd_done, set loaded_track = requested track and valid=1, then:
- -> READY if cur_track == loaded_track;
- -> SETTLE otherwise (the head moved during the transfer).
REQ-030 sd_rd and sd_wr are never high together; each request is a level held until acknowledged, never withdrawn early.
REQ-031 A transfer in flight is always completed before the head position is re-evaluated.
REQ-032 READY: ready=1; wr_byte with mode=0 sets dirty. wr_byte in any other state or with mode=1 is ignored.
REQ-033 READY with mtr=0 -> IDLE; ready=0 and dirty is retained. IDLE with mtr=1, valid=1 and a matching track -> READY with no reload.
REQ-034 img_mounted in any state:
- clears dirty and valid (unsaved writes to the old image are discarded);
- if a transfer is in flight, it completes, then the FSM goes to SETTLE;
- otherwise the FSM goes to SETTLE immediately.
REQ-035 Simultaneous events: a step and sd_done in the same cycle take both effects; the RD_WAIT exit compare uses the post-step cur_track.

Reset
REQ-036 While reset=1, all outputs and state take these values:
- state=SETTLE, counter=SETTLE, half_track=34, stp_prev=stp;
- valid=0, dirty=0, loaded_track=0;
- sd_rd=0, sd_wr=0, sd_track=0, ready=0;
- busy=1 from the first cycle after release.
REQ-037 Reset asserted mid-transfer drops sd_rd/sd_wr on the next clock edge; no completion is awaited.

Verification
REQ-038 Reset, mtr=1, no steps -> after 64000 cycles sd_rd=1 with sd_track=17; ack, then done -> ready=1.
REQ-039 From READY at half_track 34, stp 0->1->2 -> half_track=36, ready=0, settle, then sd_rd with sd_track=18.
REQ-040 In READY, 5 wr_byte pulses with mode=0, then step to track 18 -> sd_wr with sd_track=17 first; after its done, sd_rd with sd_track=18.
REQ-041 At half_track 0, stp steps outward (d=3) -> half_track stays 0 and tr00_sense_n=0; at 83, inward steps stay at 83.
REQ-042 Head steps to track 20 during RD_WAIT for track 17 -> done sets loaded_track=17, FSM goes to SETTLE, then sd_rd with sd_track=20; sd_rd and sd_wr never overlap.
REQ-043 Dirty buffer plus img_mounted -> no sd_wr is issued; sd_rd for cur_track follows.
